// File: rtl/pc_unit.sv
// rtl/pc_unit.sv - Fetch program counter with handshake, EX redirect resolution and misalign trap.
// Optional direct-mapped branch target buffer enabled by defining PC_BTB_EN.
module pc_unit #(
    parameter int                XLEN      = 32,
    parameter logic [XLEN-1:0]   RESET_PC  = '0,
    parameter logic [XLEN-1:0]   TRAP_PC   = 'h1C00,
    parameter int                BTB_DEPTH = 16
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            stall,
    output logic            fetch_valid,
    input  logic            fetch_ready,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] npc,
    input  logic            ex_valid,
    input  logic [XLEN-1:0] ex_pc,
    input  logic [XLEN-1:0] ex_pred_npc,
    input  logic [XLEN-1:0] imm,
    input  logic [XLEN-1:0] y,
    input  logic [2:0]      cmp,
    input  logic [2:0]      branch,
    input  logic [1:0]      pcsrc,
    output logic            redirect,
    output logic            misalign
);
    localparam logic [XLEN-1:0] FOUR = XLEN'(4);

    logic [XLEN-1:0] pc_q, pc_d;
    logic            run_q;
    logic            taken;
    logic            is_branch;
    logic [XLEN-1:0] target;
    logic [XLEN-1:0] pred;
    logic            hold;

    assign taken     = |(cmp & branch);
    assign is_branch = (pcsrc == 2'b00) || (pcsrc == 2'b11);

    always_comb begin
        target = ex_pc + FOUR;
        case (pcsrc)
            2'b01:   target = y;
            2'b10:   target = {y[XLEN-1:1], 1'b0};
            default: target = taken ? ex_pc + {imm[XLEN-2:0], 1'b0} : ex_pc + FOUR;
        endcase
    end

    assign misalign    = ex_valid & (target[1:0] != 2'b00);
    assign redirect    = ex_valid & (misalign | (target != ex_pred_npc));
    assign fetch_valid = run_q & ~stall;

    // Advance only on an accepted request; before run is set nothing is requested, so hold.
    assign hold = stall | ~run_q | (fetch_valid & ~fetch_ready);

`ifdef PC_BTB_EN
    localparam int IDX_W = $clog2(BTB_DEPTH);
    localparam int TAG_W = XLEN - IDX_W - 2;

    logic             btb_valid_q [BTB_DEPTH];
    logic [TAG_W-1:0] btb_tag_q   [BTB_DEPTH];
    logic [XLEN-1:0]  btb_tgt_q   [BTB_DEPTH];
    logic [IDX_W-1:0] rd_idx, wr_idx;
    logic [TAG_W-1:0] rd_tag, wr_tag;
    logic             btb_hit;
    logic             btb_wr, btb_clr;

    assign rd_idx  = pc_q[IDX_W+1:2];
    assign rd_tag  = pc_q[XLEN-1:IDX_W+2];
    assign wr_idx  = ex_pc[IDX_W+1:2];
    assign wr_tag  = ex_pc[XLEN-1:IDX_W+2];
    assign btb_hit = btb_valid_q[rd_idx] && (btb_tag_q[rd_idx] == rd_tag);
    assign pred    = btb_hit ? btb_tgt_q[rd_idx] : pc_q + FOUR;

    assign btb_wr  = ex_valid & ~misalign & ((is_branch & taken) | (pcsrc == 2'b01));
    assign btb_clr = ex_valid & ~misalign & is_branch & ~taken &
                     btb_valid_q[wr_idx] & (btb_tag_q[wr_idx] == wr_tag);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < BTB_DEPTH; i++) btb_valid_q[i] <= 1'b0;
        end else if (btb_wr) begin
            btb_valid_q[wr_idx] <= 1'b1;
        end else if (btb_clr) begin
            btb_valid_q[wr_idx] <= 1'b0;
        end
    end

    // Tag/target payload needs no reset: it is only ever read behind a valid bit.
    always_ff @(posedge clk) begin
        if (btb_wr) begin
            btb_tag_q[wr_idx] <= wr_tag;
            btb_tgt_q[wr_idx] <= target;
        end
    end
`else
    assign pred = pc_q + FOUR;
`endif

    always_comb begin
        pc_d = pred;
        if (misalign)      pc_d = TRAP_PC;
        else if (redirect) pc_d = target;
        else if (hold)     pc_d = pc_q;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pc_q  <= RESET_PC;
            run_q <= 1'b0;
        end else begin
            pc_q  <= pc_d;
            run_q <= 1'b1;
        end
    end

    assign pc  = pc_q;
    assign npc = pc_d;
endmodule

// File: tb/tb_pc_unit.sv
// tb/tb_pc_unit.sv - Directed self-checking bench for pc_unit with an expected-PC scoreboard.
module tb_pc_unit;
    logic        clk;
    logic        rstn;
    logic        stall;
    logic        fetch_valid;
    logic        fetch_ready;
    logic [31:0] pc;
    logic [31:0] npc;
    logic        ex_valid;
    logic [31:0] ex_pc;
    logic [31:0] ex_pred_npc;
    logic [31:0] imm;
    logic [31:0] y;
    logic [2:0]  cmp;
    logic [2:0]  branch;
    logic [1:0]  pcsrc;
    logic        redirect;
    logic        misalign;

    int errors = 0;
    int checks = 0;
    logic [31:0] exp_q[$];
    string       tag_q[$];

    pc_unit dut (
        .clk(clk), .rstn(rstn), .stall(stall),
        .fetch_valid(fetch_valid), .fetch_ready(fetch_ready),
        .pc(pc), .npc(npc),
        .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_pred_npc(ex_pred_npc),
        .imm(imm), .y(y), .cmp(cmp), .branch(branch), .pcsrc(pcsrc),
        .redirect(redirect), .misalign(misalign)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Queue the expected pc, advance one edge, then compare away from the edge.
    task automatic step(input logic [31:0] exp, input string tag);
        exp_q.push_back(exp);
        tag_q.push_back(tag);
        @(posedge clk);
        #1;
        chk(tag_q.pop_front(), pc, exp_q.pop_front());
    endtask

    task automatic ex_set(input logic v, input logic [31:0] epc, input logic [31:0] pnpc,
                          input logic [31:0] im, input logic [31:0] yy,
                          input logic [2:0] c, input logic [2:0] b, input logic [1:0] src);
        ex_valid = v; ex_pc = epc; ex_pred_npc = pnpc; imm = im; y = yy;
        cmp = c; branch = b; pcsrc = src;
    endtask

    initial begin
        rstn = 1'b1; stall = 1'b0; fetch_ready = 1'b0;
        ex_set(1'b0, '0, '0, '0, '0, 3'b000, 3'b000, 2'b00);
        #1 rstn = 1'b0;
        #2;
        chk("reset_pc_async", pc, 32'h0);
        chk("reset_fv_async", {31'b0, fetch_valid}, 32'h0);
        step(32'h0, "reset_hold_pc");
        step(32'h0, "reset_hold_pc2");
        chk("reset_fv", {31'b0, fetch_valid}, 32'h0);

        rstn = 1'b1; fetch_ready = 1'b1;
        step(32'h0, "first_edge_pc");
        chk("first_edge_fv", {31'b0, fetch_valid}, 32'h1);
        step(32'h4, "seq_pc4");
        step(32'h8, "seq_pc8");

        fetch_ready = 1'b0;
        for (int i = 0; i < 3; i++) step(32'h8, $sformatf("backpressure_%0d", i));
        chk("bp_fv", {31'b0, fetch_valid}, 32'h1);
        fetch_ready = 1'b1; stall = 1'b1;
        #1 chk("stall_fv", {31'b0, fetch_valid}, 32'h0);
        step(32'h8, "stall_hold");
        stall = 1'b0;
        step(32'hC, "release_pcC");

        ex_set(1'b1, 32'h100, 32'h104, 32'h10, '0, 3'b001, 3'b001, 2'b00);
        #1 chk("br_taken_redirect", {31'b0, redirect}, 32'h1);
        chk("br_taken_npc", npc, 32'h120);
        chk("br_taken_misalign", {31'b0, misalign}, 32'h0);
        step(32'h120, "br_taken_pc");

        branch = 3'b100;
        #1 chk("br_nt_redirect", {31'b0, redirect}, 32'h0);
        chk("br_nt_npc", npc, 32'h124);
        step(32'h124, "br_nt_pc");

        ex_set(1'b1, 32'h100, 32'h120, 32'h10, '0, 3'b010, 3'b100, 2'b00);
        #1 chk("mispred_nt_redirect", {31'b0, redirect}, 32'h1);
        step(32'h104, "mispred_nt_pc");

        ex_set(1'b1, 32'h100, 32'h104, 32'h10, '0, 3'b100, 3'b100, 2'b11);
        #1 chk("pcsrc11_npc", npc, 32'h120);
        step(32'h120, "pcsrc11_pc");

        ex_set(1'b1, 32'h100, 32'h104, '0, 32'h205, 3'b000, 3'b000, 2'b10);
        #1 chk("jalr_redirect", {31'b0, redirect}, 32'h1);
        step(32'h204, "jalr_pc");

        y = 32'h206;
        #1 chk("jalr_misalign", {31'b0, misalign}, 32'h1);
        chk("jalr_mis_npc", npc, 32'h1C00);
        step(32'h1C00, "trap_pc");

        ex_set(1'b1, 32'h100, 32'h104, '0, 32'h300, 3'b000, 3'b000, 2'b01);
        fetch_ready = 1'b0; stall = 1'b1;
        #1 chk("jal_stall_fv", {31'b0, fetch_valid}, 32'h0);
        step(32'h300, "jal_over_stall");

        ex_set(1'b0, '0, '0, '0, '0, 3'b000, 3'b000, 2'b00);
        stall = 1'b0;
        step(32'h300, "bp_after_redirect");

        ex_set(1'b1, 32'h100, 32'h104, '0, 32'h104, 3'b000, 3'b000, 2'b01);
        #1 chk("jal_match_redirect", {31'b0, redirect}, 32'h0);
        fetch_ready = 1'b1;
        step(32'h304, "jal_match_pc");

        ex_set(1'b1, 32'h100, 32'h104, 32'h10, '0, 3'b001, 3'b001, 2'b00);
        #1 chk("pre_reset_redirect", {31'b0, redirect}, 32'h1);
        rstn = 1'b0;
        #1 chk("midreset_pc", pc, 32'h0);
        chk("midreset_fv", {31'b0, fetch_valid}, 32'h0);
        step(32'h0, "midreset_hold");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
